ofs_fim_axis_pkt_fifo: RTL and testbench
========================================

Name: ofs_fim_axis_pkt_fifo

Overview:
Single-clock AXI-S store-and-forward packet FIFO. It is the read-side counterpart to our pipelined-ready CDC crossing. It sits after a clock crossing, in front of consumers that must not see a packet until the whole packet has arrived (e.g. PCIe TX arbitration). It buffers beats and presents a packet on the source side only once its tlast beat is stored, with a cut-through escape so that oversize packets cannot deadlock.

Parameters:
TDATA_WIDTH, 512, tdata width in bits (tkeep is TDATA_WIDTH/8)
TUSER_WIDTH, 10, tuser_vendor width in bits
DEPTH_LOG2, 6, buffer depth is 2**DEPTH_LOG2 beats (minimum 2)

Ports:
clk  in  1  single clock for both sides
rst_n  in  1  asynchronous, active-low reset
s_tvalid  in  1  sink beat valid
s_tready  out  1  sink ready
s_tdata  in  TDATA_WIDTH  sink data
s_tkeep  in  TDATA_WIDTH/8  sink byte enables
s_tuser_vendor  in  TUSER_WIDTH  sink sideband
s_tlast  in  1  sink end of packet
m_tvalid  out  1  source beat valid
m_tready  in  1  source ready
m_tdata  out  TDATA_WIDTH  source data
m_tkeep  out  TDATA_WIDTH/8  source byte enables
m_tuser_vendor  out  TUSER_WIDTH  source sideband
m_tlast  out  1  source end of packet
pkt_cnt  out  DEPTH_LOG2+1  complete packets held, including the output register
used  out  DEPTH_LOG2+1  beats held, including the output register

Behaviour:
- Reset: one clock (clk); reset is asynchronous, active-low (rst_n). While rst_n=0, all of the following are 0: m_tvalid, s_tready, pkt_cnt, used, the pointers and the cut-through flag. m_tdata, m_tkeep, m_tuser_vendor and m_tlast are don't-care but must hold their value while m_tvalid=0. Reset mid-packet discards all contents, with no partial output.
- s_tready = rst_n && (used < 2**DEPTH_LOG2). Capacity is 2**DEPTH_LOG2 beats in total, RAM plus output register. A write occurs when s_tvalid && s_tready.
- Storage is a simple dual-port RAM with registered read, plus one output register (show-ahead). The pointers are DEPTH_LOG2 bits wide and wrap naturally.
- pkt_cnt rules:
  - Increments the cycle after a write with s_tlast=1.
  - Decrements the cycle after an output handshake with m_tlast=1.
  - If both events occur in the same cycle, pkt_cnt is unchanged.
- Release rule: beats may advance into the output register only when (pkt_cnt > 0) or cut_thru=1.
- cut_thru:
  - Set when used reaches 2**DEPTH_LOG2 and pkt_cnt = 0.
  - Cleared when a beat with tlast=1 leaves the source port.
  - While it is set, the oldest packet streams out beat-by-beat.
- Latency: when the FIFO is empty, m_tvalid rises exactly 2 cycles after the write handshake of the tlast beat. With back-to-back stored beats, sustained throughput is 1 beat/clk on both sides.
- AXI-S rules:
  - Once m_tvalid=1, m_tvalid and all m_* payload stay stable until m_tready=1.
  - m_tvalid never depends combinationally on m_tready.
  - s_tready never depends combinationally on s_tvalid.
- Simultaneous write and read while full: the write is refused (s_tready=0 registered from used). No beat is lost or duplicated.
- Beat order and all of tdata, tkeep, tuser_vendor and tlast are preserved bit-exactly.

Decomposition:
- Package ofs_fim_axis_pkt_fifo_pkg holds:
  - typedef t_axis_beat, a packed struct of tdata, tkeep, tuser_vendor and tlast, parameterized through localparams in the top module.
  - Constants for the minimum DEPTH_LOG2.
- One sub-module, ofs_fim_axis_pkt_fifo_ram: simple dual-port RAM, registered read, width $bits(t_axis_beat), depth 2**DEPTH_LOG2.
- All control logic (pointers, used, pkt_cnt, cut_thru, output register) stays in the top module.

Test Plan:
1. DEPTH_LOG2=4. Write a 3-beat packet with data 0x1,0x2,0x3 while m_tready=1 → m_tvalid stays 0 until 2 cycles after the beat-3 handshake. Then 0x1,0x2,0x3 emerge on consecutive cycles, tlast only on 0x3, and pkt_cnt goes 1→0.
2. m_tready=0. Write four 4-beat packets → used=16 and s_tready=0 after the 16th beat, pkt_cnt=4. Then raise m_tready → all 16 beats emerge in order, and s_tready returns to 1 the cycle after the first read.
3. DEPTH_LOG2=4. Write a 20-beat packet with m_tready=1 → cut_thru sets when used=16. Beats 0..19 emerge intact and in order, with no deadlock. cut_thru clears after the tlast beat, and pkt_cnt never underflows.
4. Continuous 1-beat packets, with s_tvalid=1 and m_tready=1 every cycle → after the initial 2-cycle latency, 1 beat/clk, with pkt_cnt stable through the same-cycle increment and decrement.
5. Randomized m_tready with 30% stall → m_* payload holds stable while m_tvalid && !m_tready. The scoreboard matches all beats and sideband.
6. Assert rst_n=0 asynchronously mid-packet, with used=5 → m_tvalid, s_tready, used and pkt_cnt go to 0 immediately. After release, a new 2-beat packet passes correctly, with no stale beats.

Source files
------------

// File: rtl/ofs_fim_axis_pkt_fifo_pkg.sv
// Shared types and constants for the AXI-S store-and-forward packet FIFO.
package ofs_fim_axis_pkt_fifo_pkg;

    // Smallest legal buffer: two beats.
    localparam int MIN_DEPTH_LOG2   = 1;

    localparam int DFLT_TDATA_WIDTH = 512;
    localparam int DFLT_TUSER_WIDTH = 10;
    localparam int DFLT_DEPTH_LOG2  = 6;

    // One stored beat at the default widths. The top module builds the same
    // layout from its own width parameters for non-default configurations.
    typedef struct packed {
        logic [DFLT_TDATA_WIDTH-1:0]   tdata;
        logic [DFLT_TDATA_WIDTH/8-1:0] tkeep;
        logic [DFLT_TUSER_WIDTH-1:0]   tuser_vendor;
        logic                          tlast;
    } t_axis_beat;

endpackage

// File: rtl/ofs_fim_axis_pkt_fifo_ram.sv
// Simple dual-port RAM with registered read; read data holds while i_rd_en=0.
module ofs_fim_axis_pkt_fifo_ram #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 6
) (
    input  logic                  i_clk,
    input  logic                  i_wr_en,
    input  logic [DEPTH_LOG2-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]      i_wr_data,
    input  logic                  i_rd_en,
    input  logic [DEPTH_LOG2-1:0] i_rd_addr,
    output logic [WIDTH-1:0]      o_rd_data
);

    logic [WIDTH-1:0] r_mem [2**DEPTH_LOG2];
    logic [WIDTH-1:0] r_rd_data;

    // Write port and registered read port.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/ofs_fim_axis_pkt_fifo.sv
// Single-clock AXI-S store-and-forward packet FIFO with cut-through escape
// for packets larger than the buffer.
module ofs_fim_axis_pkt_fifo
    import ofs_fim_axis_pkt_fifo_pkg::*;
#(
    parameter int TDATA_WIDTH = 512,
    parameter int TUSER_WIDTH = 10,
    parameter int DEPTH_LOG2  = 6
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       s_tvalid,
    output logic                       s_tready,
    input  logic [TDATA_WIDTH-1:0]     s_tdata,
    input  logic [TDATA_WIDTH/8-1:0]   s_tkeep,
    input  logic [TUSER_WIDTH-1:0]     s_tuser_vendor,
    input  logic                       s_tlast,
    output logic                       m_tvalid,
    input  logic                       m_tready,
    output logic [TDATA_WIDTH-1:0]     m_tdata,
    output logic [TDATA_WIDTH/8-1:0]   m_tkeep,
    output logic [TUSER_WIDTH-1:0]     m_tuser_vendor,
    output logic                       m_tlast,
    output logic [DEPTH_LOG2:0]        pkt_cnt,
    output logic [DEPTH_LOG2:0]        used
);

    localparam int TKEEP_WIDTH = TDATA_WIDTH / 8;
    localparam int DEPTH       = 2**DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   FULL    = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

    if (DEPTH_LOG2 < MIN_DEPTH_LOG2) begin : g_depth_chk
        $error("ofs_fim_axis_pkt_fifo: DEPTH_LOG2 below minimum");
    end

    typedef struct packed {
        logic [TDATA_WIDTH-1:0] tdata;
        logic [TKEEP_WIDTH-1:0] tkeep;
        logic [TUSER_WIDTH-1:0] tuser_vendor;
        logic                   tlast;
    } t_beat;

    logic [DEPTH_LOG2-1:0] r_wr_ptr, r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_used, r_pkt_cnt, r_pkt_rd;
    logic                  r_cut_thru, r_ct_last_rd;
    logic                  r_rd_vld, r_m_vld;
    t_beat                 r_m_beat;
    logic [DEPTH-1:0]      r_last_mem;

    t_beat                 w_wr_beat, w_rd_data;
    logic [DEPTH_LOG2:0]   w_ram_cnt;
    logic                  w_wr, w_m_hs, w_load_out, w_release, w_rd_issue;
    logic                  w_rd_last, w_in_last, w_out_last, w_ct_set;

    assign w_wr_beat  = '{tdata: s_tdata, tkeep: s_tkeep,
                          tuser_vendor: s_tuser_vendor, tlast: s_tlast};
    assign s_tready   = rst_n && (r_used < FULL);
    assign w_wr       = s_tvalid && s_tready;
    assign w_m_hs     = r_m_vld && m_tready;
    assign w_load_out = r_rd_vld && (!r_m_vld || m_tready);
    // Beats still in RAM, i.e. not yet in the read stage or output register.
    assign w_ram_cnt  = r_used - (r_rd_vld ? CNT_ONE : '0) - (r_m_vld ? CNT_ONE : '0);
    assign w_rd_last  = r_last_mem[r_rd_ptr];
    // r_pkt_rd counts complete packets whose tlast is still in RAM, so a
    // partial follow-on packet can never slip into the output register.
    assign w_release  = (r_pkt_rd != '0) || (r_cut_thru && !r_ct_last_rd);
    assign w_rd_issue = (w_ram_cnt != '0) && w_release && (!r_rd_vld || w_load_out);
    assign w_in_last  = w_wr && s_tlast;
    assign w_out_last = w_m_hs && r_m_beat.tlast;
    assign w_ct_set   = (r_used == FULL) && (r_pkt_cnt == '0);

    ofs_fim_axis_pkt_fifo_ram #(
        .WIDTH      ($bits(t_beat)),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .i_clk     (clk),
        .i_wr_en   (w_wr),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (w_wr_beat),
        .i_rd_en   (w_rd_issue),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_rd_data)
    );

    // Shadow of each slot's tlast so release can be decided before the read.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_last_mem[r_wr_ptr] <= s_tlast;
        end
    end

    // Pointers, occupancy and packet counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_used    <= '0;
            r_pkt_cnt <= '0;
            r_pkt_rd  <= '0;
        end else begin
            if (w_wr)       r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_rd_issue) r_rd_ptr <= r_rd_ptr + PTR_ONE;
            r_used    <= r_used + (w_wr ? CNT_ONE : '0) - (w_m_hs ? CNT_ONE : '0);
            r_pkt_cnt <= r_pkt_cnt + (w_in_last ? CNT_ONE : '0)
                                   - (w_out_last ? CNT_ONE : '0);
            r_pkt_rd  <= r_pkt_rd + (w_in_last ? CNT_ONE : '0)
                                  - ((w_rd_issue && w_rd_last) ? CNT_ONE : '0);
        end
    end

    // Cut-through: set on a full buffer with no complete packet, held until
    // the oversize packet's tlast leaves the source port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cut_thru   <= 1'b0;
            r_ct_last_rd <= 1'b0;
        end else if (w_out_last) begin
            r_cut_thru   <= 1'b0;
            r_ct_last_rd <= 1'b0;
        end else begin
            if (w_ct_set) r_cut_thru <= 1'b1;
            if (r_cut_thru && w_rd_issue && w_rd_last) r_ct_last_rd <= 1'b1;
        end
    end

    // Read stage and show-ahead output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_vld <= 1'b0;
            r_m_vld  <= 1'b0;
            r_m_beat <= '0;
        end else begin
            if (w_rd_issue)      r_rd_vld <= 1'b1;
            else if (w_load_out) r_rd_vld <= 1'b0;
            if (w_load_out) begin
                r_m_vld  <= 1'b1;
                r_m_beat <= w_rd_data;
            end else if (w_m_hs) begin
                r_m_vld  <= 1'b0;
            end
        end
    end

    assign m_tvalid       = r_m_vld;
    assign m_tdata        = r_m_beat.tdata;
    assign m_tkeep        = r_m_beat.tkeep;
    assign m_tuser_vendor = r_m_beat.tuser_vendor;
    assign m_tlast        = r_m_beat.tlast;
    assign pkt_cnt        = r_pkt_cnt;
    assign used           = r_used;

endmodule

// File: tb/tb_ofs_fim_axis_pkt_fifo.sv
// Bench for the packet FIFO: queue-based reference model checked every cycle
// plus directed literal expectations for latency, capacity and reset.
module tb_ofs_fim_axis_pkt_fifo;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_tvalid, s_tready, s_tlast;
    logic [31:0] s_tdata;
    logic [3:0]  s_tkeep;
    logic [9:0]  s_tuser_vendor;
    logic        m_tvalid, m_tready, m_tlast;
    logic [31:0] m_tdata;
    logic [3:0]  m_tkeep;
    logic [9:0]  m_tuser_vendor;
    logic [4:0]  pkt_cnt, used;

    int n_vec = 0;
    int n_err = 0;
    int n_out = 0;
    int max_used = 0;
    logic rnd_en = 1'b0;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  k;
        logic [9:0]  u;
        logic        l;
    } beat_t;

    beat_t exp_q[$];

    ofs_fim_axis_pkt_fifo #(
        .TDATA_WIDTH (32),
        .TUSER_WIDTH (10),
        .DEPTH_LOG2  (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .s_tvalid       (s_tvalid),
        .s_tready       (s_tready),
        .s_tdata        (s_tdata),
        .s_tkeep        (s_tkeep),
        .s_tuser_vendor (s_tuser_vendor),
        .s_tlast        (s_tlast),
        .m_tvalid       (m_tvalid),
        .m_tready       (m_tready),
        .m_tdata        (m_tdata),
        .m_tkeep        (m_tkeep),
        .m_tuser_vendor (m_tuser_vendor),
        .m_tlast        (m_tlast),
        .pkt_cnt        (pkt_cnt),
        .used           (used)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the queue model; handshakes visible at the
    // falling edge commit at the next rising edge and are applied afterwards.
    logic        hold_vld = 1'b0;
    beat_t       held;
    logic        ct_flag = 1'b0;
    always @(negedge clk) begin
        int n_last;
        if (!rst_n) begin
            check("rst_m_tvalid", m_tvalid, 0);
            check("rst_s_tready", s_tready, 0);
            check("rst_used", used, 0);
            check("rst_pkt_cnt", pkt_cnt, 0);
            exp_q.delete();
            ct_flag  = 1'b0;
            hold_vld = 1'b0;
        end else begin
            n_last = 0;
            foreach (exp_q[i]) if (exp_q[i].l) n_last++;
            if (int'(used) > max_used) max_used = int'(used);
            check("used", used, exp_q.size());
            check("pkt_cnt", pkt_cnt, n_last);
            check("s_tready", s_tready, exp_q.size() < 16);
            if (exp_q.size() == 16 && n_last == 0) ct_flag = 1'b1;
            if (hold_vld) begin
                check("stall_tvalid", m_tvalid, 1);
                check("stall_payload", {m_tdata, m_tkeep, m_tuser_vendor, m_tlast},
                      {held.d, held.k, held.u, held.l});
            end
            if (m_tvalid) begin
                if (exp_q.size() == 0) begin
                    check("tvalid_when_empty", m_tvalid, 0);
                end else begin
                    check("m_tdata", m_tdata, exp_q[0].d);
                    check("m_tkeep", m_tkeep, exp_q[0].k);
                    check("m_tuser", m_tuser_vendor, exp_q[0].u);
                    check("m_tlast", m_tlast, exp_q[0].l);
                    check("released_early", (n_last > 0) || ct_flag, 1);
                end
            end
            hold_vld = m_tvalid && !m_tready;
            held     = '{m_tdata, m_tkeep, m_tuser_vendor, m_tlast};
            if (m_tvalid && m_tready && exp_q.size() > 0) begin
                if (exp_q[0].l) ct_flag = 1'b0;
                void'(exp_q.pop_front());
                n_out++;
            end
            if (s_tvalid && s_tready)
                exp_q.push_back('{s_tdata, s_tkeep, s_tuser_vendor, s_tlast});
        end
    end

    // Random back-pressure, roughly 30% stall.
    always @(posedge clk) begin
        #2;
        if (rnd_en) m_tready = ($urandom_range(0, 99) >= 30);
    end

    // Drive one beat starting at posedge+1; returns at posedge+1 after its handshake.
    task automatic send_beat(input logic [31:0] d, input logic [3:0] k,
                             input logic [9:0] u, input logic l);
        int   guard = 0;
        logic acc = 1'b0;
        s_tvalid = 1'b1; s_tdata = d; s_tkeep = k; s_tuser_vendor = u; s_tlast = l;
        while (!acc && guard < 500) begin
            @(negedge clk);
            acc = s_tready;
            @(posedge clk); #1;
            guard++;
        end
        check("send_timeout", acc, 1);
        s_tvalid = 1'b0;
    endtask

    task automatic wait_empty(input int budget);
        int cyc = 0;
        while (used != 0 && cyc < budget) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("drain_timeout", used != 0, 0);
    endtask

    initial begin
        int base;
        rst_n = 1'b0; s_tvalid = 1'b0; s_tdata = '0; s_tkeep = '0;
        s_tuser_vendor = '0; s_tlast = 1'b0; m_tready = 1'b1;
        repeat (3) @(posedge clk); #1;
        check("lit_rst_used", used, 0);
        check("lit_rst_s_tready", s_tready, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("lit_idle_s_tready", s_tready, 1);

        // 1: 3-beat packet, latency and ordering
        send_beat(32'h1, 4'hF, 10'h001, 1'b0);
        send_beat(32'h2, 4'hF, 10'h002, 1'b0);
        send_beat(32'h3, 4'hF, 10'h003, 1'b1);
        check("t1_vld_c0", m_tvalid, 0);
        check("t1_pkt_cnt", pkt_cnt, 1);
        check("t1_used", used, 3);
        @(posedge clk); #1;
        check("t1_vld_c1", m_tvalid, 0);
        @(posedge clk); #1;
        check("t1_vld_c2", m_tvalid, 1);
        check("t1_data0", {m_tdata, m_tlast}, {32'h1, 1'b0});
        @(posedge clk); #1;
        check("t1_data1", {m_tvalid, m_tdata, m_tlast}, {1'b1, 32'h2, 1'b0});
        @(posedge clk); #1;
        check("t1_data2", {m_tvalid, m_tdata, m_tlast}, {1'b1, 32'h3, 1'b1});
        @(posedge clk); #1;
        check("t1_vld_end", m_tvalid, 0);
        check("t1_pkt_end", pkt_cnt, 0);

        // 2: fill to capacity with four 4-beat packets, then drain
        m_tready = 1'b0;
        for (int i = 0; i < 16; i++)
            send_beat(32'h100 + i, 4'hF, 10'(i), (i % 4) == 3);
        check("t2_used_full", used, 16);
        check("t2_s_tready_full", s_tready, 0);
        check("t2_pkt_cnt", pkt_cnt, 4);
        repeat (3) @(posedge clk); #1;
        check("t2_head", {m_tvalid, m_tdata}, {1'b1, 32'h100});
        base = n_out;
        m_tready = 1'b1;
        @(negedge clk);
        check("t2_s_tready_pre", s_tready, 0);
        @(posedge clk); #1;
        check("t2_s_tready_post", s_tready, 1);
        check("t2_used_post", used, 15);
        wait_empty(100);
        check("t2_out_cnt", n_out - base, 16);

        // 3: oversize 20-beat packet through cut-through
        max_used = 0;
        base = n_out;
        for (int i = 0; i < 20; i++)
            send_beat(32'h200 + i, 4'h3, 10'(9'h100 + i), i == 19);
        wait_empty(200);
        check("t3_max_used", max_used, 16);
        check("t3_out_cnt", n_out - base, 20);
        check("t3_pkt_cnt", pkt_cnt, 0);

        // 4: back-to-back single-beat packets
        base = n_out;
        for (int i = 0; i < 12; i++)
            send_beat(32'h300 + i, 4'h1, 10'(i), 1'b1);
        check("t4_out_rate", n_out - base, 9);
        check("t4_pkt_cnt", pkt_cnt, 3);
        check("t4_used", used, 3);
        wait_empty(50);
        check("t4_out_cnt", n_out - base, 12);

        // 5: random back-pressure over packets of 5, 1 and 7 beats
        rnd_en = 1'b1;
        base = n_out;
        for (int p = 0; p < 3; p++) begin
            int len;
            len = (p == 0) ? 5 : (p == 1) ? 1 : 7;
            for (int b = 0; b < len; b++)
                send_beat($urandom, 4'($urandom_range(0, 15)),
                          10'($urandom_range(0, 1023)), b == len - 1);
        end
        wait_empty(500);
        rnd_en = 1'b0;
        m_tready = 1'b1;
        check("t5_out_cnt", n_out - base, 13);

        // 6: asynchronous reset with five beats held mid-packet
        m_tready = 1'b0;
        send_beat(32'h500, 4'hF, 10'h050, 1'b0);
        send_beat(32'h501, 4'hF, 10'h051, 1'b0);
        send_beat(32'h502, 4'hF, 10'h052, 1'b1);
        send_beat(32'h510, 4'hF, 10'h060, 1'b0);
        send_beat(32'h511, 4'hF, 10'h061, 1'b0);
        check("t6_used_pre", used, 5);
        check("t6_vld_pre", m_tvalid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_vld", m_tvalid, 0);
        check("t6_rst_s_tready", s_tready, 0);
        check("t6_rst_used", used, 0);
        check("t6_rst_pkt_cnt", pkt_cnt, 0);
        repeat (2) @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("t6_used_after", used, 0);
        m_tready = 1'b1;
        base = n_out;
        send_beat(32'h600, 4'hA, 10'h3AA, 1'b0);
        send_beat(32'h601, 4'h5, 10'h155, 1'b1);
        wait_empty(50);
        check("t6_out_cnt", n_out - base, 2);
        check("t6_pkt_cnt", pkt_cnt, 0);
        repeat (3) @(posedge clk); #1;
        check("t6_no_stale", m_tvalid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
